// File: rtl/i2c_fifo_ctrl.sv
// Pointer/flag controller for the I2C TX/RX FIFOs; drives an external dual-port RAM.
// Optional sticky overflow/underflow flags: define I2C_FIFO_CTRL_ERR_EN.
module i2c_fifo_ctrl #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 4,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_pop_data,
    output logic              o_pop_valid,
    output logic              o_ram_wr_en,
    output logic [AWIDTH-1:0] o_ram_wr_addr,
    output logic [DWIDTH-1:0] o_ram_wr_data,
    output logic              o_ram_rd_en,
    output logic [AWIDTH-1:0] o_ram_rd_addr,
    input  logic [DWIDTH-1:0] i_ram_rd_data,
    output logic [AWIDTH:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_overflow,
    output logic              o_underflow,
    input  logic              i_err_clr
);

    localparam int              DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0] C_DEPTH  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] C_ONE    = (AWIDTH+1)'(1);
    // Margins that reach past the FIFO size pin the flag permanently on.
    localparam logic [AWIDTH:0] C_AF_LVL = (AF_MARGIN >= DEPTH) ? '0 : (AWIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [AWIDTH:0] C_AE_LVL = (AE_MARGIN >= DEPTH) ? C_DEPTH : (AWIDTH+1)'(AE_MARGIN);

    logic [AWIDTH:0] r_wr_ptr;
    logic [AWIDTH:0] r_rd_ptr;
    logic            r_pop_valid;
    logic [AWIDTH:0] w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_push_acc;
    logic            w_pop_acc;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_count == C_DEPTH);
    assign w_empty    = (w_count == '0);
    assign w_push_acc = i_push & ~w_full & ~i_flush;
    assign w_pop_acc  = i_pop & ~w_empty & ~i_flush;

    assign o_ram_wr_en    = w_push_acc;
    assign o_ram_wr_addr  = r_wr_ptr[AWIDTH-1:0];
    assign o_ram_wr_data  = i_push_data;
    assign o_ram_rd_en    = w_pop_acc;
    assign o_ram_rd_addr  = r_rd_ptr[AWIDTH-1:0];
    assign o_pop_data     = i_ram_rd_data;
    assign o_pop_valid    = r_pop_valid;

    assign o_count        = w_count;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (w_count >= C_AF_LVL);
    assign o_almost_empty = (w_count <= C_AE_LVL);

    // Pointer stage: the wrap bit falls out of the AWIDTH+1 bit increment.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pop_valid <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + C_ONE;
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + C_ONE;
            r_pop_valid <= w_pop_acc;
        end
    end

`ifdef I2C_FIFO_CTRL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error event wins over a same-cycle clear.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_push & w_full & ~i_flush)  r_overflow <= 1'b1;
            else if (i_err_clr)              r_overflow <= 1'b0;
            if (i_pop & w_empty & ~i_flush)  r_underflow <= 1'b1;
            else if (i_err_clr)              r_underflow <= 1'b0;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = i_err_clr;
    assign o_overflow       = 1'b0;
    assign o_underflow      = 1'b0;
`endif

endmodule

// File: doc/i2c_fifo_ctrl.md
# i2c_fifo_ctrl

- Pointer/flag controller for the I2C block's TX and RX FIFOs.
- Drives the write and read ports of an external dual-port RAM of 2**AWIDTH words and presents a push/pop handshake to the APB register side and the I2C engine.
- Owns all occupancy state: pointers, count, full/empty, thresholds and error flags.
- Holds no data storage itself.

## Interface
- DWIDTH, 32, data word width
- AWIDTH, 4, RAM address width; DEPTH = 2**AWIDTH entries, all usable
- AF_MARGIN, 2, almost_full when count >= DEPTH - AF_MARGIN
- AE_MARGIN, 2, almost_empty when count <= AE_MARGIN

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous clear of pointers and count
- push  in  1  write request
- push_data  in  DWIDTH  write word
- pop  in  1  read request
- pop_data  out  DWIDTH  read word, valid while pop_valid=1
- pop_valid  out  1  one-cycle strobe for an accepted pop
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  AWIDTH  RAM write address
- ram_wr_data  out  DWIDTH  RAM write data
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  AWIDTH  RAM read address
- ram_rd_data  in  DWIDTH  RAM read data, valid the cycle after ram_rd_en
- count  out  AWIDTH+1  occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1 each  status
- overflow, underflow  out  1 each  sticky error flags (see Configuration)
- err_clr  in  1  clears overflow/underflow

## Operation
- State:
  - wr_ptr and rd_ptr are AWIDTH+1 bits; MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2**(AWIDTH+1).
  - full = (count == DEPTH); empty = (count == 0).
  - Threshold compares are unsigned on AWIDTH+1 bits.
- Push accept: push_acc = push & ~full & ~flush.
  - When push_acc=1: ram_wr_en=1, ram_wr_addr=wr_ptr[AWIDTH-1:0], ram_wr_data=push_data, all combinational in the same cycle.
  - wr_ptr increments at the edge.
- Pop accept: pop_acc = pop & ~empty & ~flush.
  - When pop_acc=1: ram_rd_en=1 and ram_rd_addr=rd_ptr[AWIDTH-1:0], combinational.
  - rd_ptr increments at the edge.
- pop_valid is registered pop_acc. pop_data is a direct pass-through of ram_rd_data.
- Simultaneous push and pop, decided on pre-edge count:
  - Neither full nor empty: both accepted, count unchanged. Addresses never collide in this case.
  - Full: pop accepted, push rejected.
  - Empty: push accepted, pop rejected. No same-cycle bypass.
- Wrap-around: the low pointer bits roll DEPTH-1 -> 0; the MSB toggles.
- Flush:
  - Sets wr_ptr=rd_ptr=0 and pop_valid=0 at the next edge.
  - Overrides push/pop, and ram_wr_en/ram_rd_en stay 0 that cycle.
  - Error flags are unaffected.
- When push/pop are idle, ram_wr_en and ram_rd_en are 0. Addresses continue to reflect the pointers.

## Timing
- Reset values:
  - wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, pop_valid=0, overflow=0, underflow=0.
  - almost_full=0, unless AF_MARGIN >= DEPTH.
  - ram_* outputs follow from the reset pointers with enables 0.
- Reset asserted mid-operation clears all state immediately; any in-flight pop_valid is dropped.
- Status outputs are combinational decodes of the registered pointers, so they change one cycle after the accepting edge.
- Pop latency: pop sampled high at edge N gives pop_valid=1 and valid pop_data during cycle N+1.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro: I2C_FIFO_CTRL_ERR_EN.
- Defined:
  - overflow sets on (push & full & ~flush); underflow sets on (pop & empty & ~flush).
  - Both are sticky until err_clr or reset.
  - Set has priority over err_clr in the same cycle.
- Not defined: overflow and underflow are tied to 0; err_clr is ignored.
- Pointer behaviour is identical in both builds.

## Test plan
All scenarios use DWIDTH=32, AWIDTH=4, AF_MARGIN=2, AE_MARGIN=2.
- Reset, then push 0x00..0x0F on 16 consecutive cycles -> count reaches 16, full=1, almost_full=1 from count=14, ram_wr_addr steps 0..15.
- Full FIFO, push 0xDEAD -> no ram_wr_en, count stays 16, overflow=1 (macro on) / 0 (macro off). Then err_clr -> overflow=0.
- Pop 16 times -> pop_data returns 0x00..0x0F on pop_valid one cycle after each pop, empty=1 at the end. One more pop -> ram_rd_en=0, no pop_valid, underflow=1.
- Count=5, push and pop in the same cycle for 20 cycles -> count holds 5, pointers wrap past 15, data order preserved.
- Empty, push+pop same cycle -> push accepted, pop rejected, count=1. Full, push+pop -> pop accepted, count=15.
- Count=7, assert flush with push=1 -> no RAM write, count=0, empty=1 next cycle. Async reset mid-stream -> all outputs at reset values without a clock edge.
